dmem_responder: RTL
===================

Name: dmem_responder

Overview:
- Handshaked data-memory responder: the target end of the core's load/store interface, replacing the zero-latency data memory once the core gains a stall-capable memory port.
- Accepts one request at a time over a valid/ready channel and performs a word read or a byte-enabled write.
- Returns a response after a programmable number of wait cycles, with an error flag for misaligned or out-of-range addresses.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words stored; must be a power of two.
- WAIT_CYCLES, 2, extra cycles between request acceptance and response; 0..15.

Ports:
- clk  input  1  rising-edge clock
- areset  input  1  asynchronous, active-low reset
- req_valid  input  1  request present
- req_ready  output  1  responder can accept a request this cycle
- req_we  input  1  1 = write, 0 = read
- req_addr  input  32  byte address
- req_wdata  input  32  write data
- req_be  input  4  byte enables; bit i selects wdata[8i+7:8i]
- rsp_valid  output  1  response present
- rsp_ready  input  1  requester takes the response
- rsp_rdata  output  32  read data; 0 for writes and errors
- rsp_err  output  1  request was misaligned or out of range

Behaviour:
- Reset (areset low, asynchronous):
  - state = IDLE; req_ready = 1; rsp_valid = 0; rsp_rdata = 0; rsp_err = 0; wait counter = 0.
  - Storage contents are not reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready = 1.
  - On req_valid high at a rising edge: latch we, addr, wdata, be; load counter = WAIT_CYCLES; go to WAIT.
- WAIT:
  - req_ready = 0.
  - Counter nonzero: decrement.
  - Counter zero: commit the operation at this edge and go to RESP.
- Commit:
  - Error when addr[1:0] != 0, or word index addr[31:2] >= DEPTH_WORDS.
  - On error: nothing is written; rsp_rdata = 0; rsp_err = 1.
  - Valid write: update only the bytes whose enable is set. req_be = 0 is legal: no change, err = 0. rsp_rdata = 0.
  - Valid read: rsp_rdata = the full word read at the commit edge. be is ignored.
- RESP:
  - rsp_valid = 1; rsp_rdata and rsp_err are held stable until accepted.
  - Response is accepted when rsp_valid and rsp_ready are both high at an edge; then go to IDLE and clear rsp_valid, rsp_rdata and rsp_err.
  - The next request can be accepted no earlier than the edge after the response is accepted. There is no bypass from RESP to accept.
- Latency: with acceptance at edge E, rsp_valid is high from edge E+WAIT_CYCLES+1. WAIT_CYCLES = 0 gives a one-cycle response.
- Read-after-write to the same address returns the new data.
- Request inputs are ignored outside IDLE.
- Backpressure: rsp_ready may stay low indefinitely; the FSM holds in RESP.
- Reset mid-operation: a request in WAIT is dropped and its write is not performed. A write already committed (state RESP) persists.
- Address arithmetic: word index = addr[log2(DEPTH_WORDS)+1:2]. The range check uses the full addr[31:2], so addresses never wrap or alias.

Decomposition:
- Shared package dmem_pkg:
  - state enum {IDLE, WAIT, RESP}
  - constants WORD_BYTES = 4 and BE_WIDTH = 4
  - function addr_ok(addr, depth) covering both the alignment and range checks
- One sub-module, dmem_ram:
  - DEPTH_WORDS x 32 array, synchronous byte-enabled write, combinational read.
  - Instantiated once; the FSM, counter and error logic live in dmem_responder.

Test Plan:
- Reset, then write addr 0x10, wdata 0xDEADBEEF, be 0xF, WAIT_CYCLES = 2 -> rsp_valid rises 3 edges after acceptance with err 0 and rdata 0. A following read of 0x10 -> rdata 0xDEADBEEF.
- Partial write 0x10 with wdata 0x00001234, be 0x3, over 0xDEADBEEF -> read returns 0xDEAD1234. A write with be 0x0 leaves the word unchanged.
- Read addr 0x12 (misaligned) -> err 1, rdata 0. Write to word index 256 with DEPTH_WORDS = 256 -> err 1, and word 0 is unchanged afterwards (no alias).
- Hold rsp_ready low for 10 cycles during RESP -> rsp_valid, rdata and err stay stable. req_valid pulsed meanwhile is ignored and req_ready stays 0. Raising rsp_ready -> IDLE next edge.
- Assert areset during WAIT of a write to 0x20 (old value 0x11111111) -> all outputs return to reset values immediately. A later read of 0x20 returns 0x11111111.
- WAIT_CYCLES = 0: back-to-back requests with rsp_ready tied high -> one transaction every 3 cycles (accept, RESP, IDLE), with correct data each time.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the handshaked data-memory responder.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_e;

  localparam int WORD_BYTES = 4;
  localparam int BE_WIDTH   = 4;

  // True when addr is word aligned and its full word index lies inside the array.
  function automatic logic addr_ok(input logic [31:0] addr, input logic [31:0] depth);
    logic [31:0] word_idx;
    word_idx = {2'b00, addr[31:2]};
    return (addr[1:0] == 2'b00) && (word_idx < depth);
  endfunction

endpackage

// File: rtl/dmem_ram.sv
// Word-wide storage with synchronous byte-enabled write and combinational read.
module dmem_ram
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic                clk,
  input  logic                we,
  input  logic [BE_WIDTH-1:0] be,
  input  logic [AW-1:0]       addr,
  input  logic [31:0]         wdata,
  output logic [31:0]         rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  // Contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < BE_WIDTH; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/dmem_responder.sv
// Target end of the core's load/store port: one request at a time, response after
// a programmable wait, error flag for misaligned or out-of-range addresses.
//
// state | meaning
// IDLE  | ready for a request; req_ready high
// WAIT  | request latched, counting down the wait cycles; commits at count zero
// RESP  | response presented; held until rsp_ready
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        areset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int          AW        = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);
  localparam logic [31:0] DEPTH_W   = 32'(DEPTH_WORDS);

  dmem_state_e state, state_nxt;
  logic [3:0]  cnt;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;

  logic        commit;
  logic        ok;
  logic        ram_we;
  logic [31:0] ram_rdata;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid) state_nxt = WAIT;
      WAIT:    if (cnt == 4'd0) state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge areset) begin
    if (!areset) state <= IDLE;
    else         state <= state_nxt;
  end

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);

  assign commit = (state == WAIT) && (cnt == 4'd0);
  assign ok     = addr_ok(addr_q, DEPTH_W);
  assign ram_we = commit && we_q && ok;

  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      cnt       <= 4'd0;
      we_q      <= 1'b0;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      be_q      <= 4'd0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            we_q    <= req_we;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            be_q    <= req_be;
            cnt     <= WAIT_INIT;
          end
        end
        WAIT: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            // Read data is sampled from the array before any write at this edge.
            rsp_rdata <= (ok && !we_q) ? ram_rdata : 32'd0;
            rsp_err   <= !ok;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
          end
        end
        default: begin
          rsp_rdata <= 32'd0;
          rsp_err   <= 1'b0;
        end
      endcase
    end
  end

  dmem_ram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .be    (be_q),
    .addr  (addr_q[AW+1:2]),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

endmodule
